// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver:
// scan FSM states, the active-low a..g code table and the all-dark pattern.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        BLANK = 2'd3
    } state_t;

    localparam logic [7:0] SEG_DARK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decoder.sv
// Nibble plus decimal-point flag to the active-low {dp,g,f,e,d,c,b,a} pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup; dp input is 1 = lit, so it is inverted onto the pin level
    always_comb begin
        seg = {~dp, SEG_CODES[nibble]};
    end

endmodule

// File: rtl/seven_segment_mux_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadow-buffered data.
// Optional macro LEADING_ZERO_BLANK_EN blanks segments a..g of leading zero digits.
module seven_segment_mux_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_TICKS = 200000,
    parameter int BLANK_TICKS = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [4*N_DIGITS-1:0] DATA_IN,
    input  logic [N_DIGITS-1:0]   DP_IN,
    input  logic                  DATA_VALID,
    output logic [7:0]            SEG_OUT,
    output logic [N_DIGITS-1:0]   AN_OUT,
    output logic                  FRAME_DONE
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);

    state_t                  state_r, state_nx;
    logic [CNT_W-1:0]        cnt_r, cnt_nx;
    logic [IDX_W-1:0]        idx_r, idx_nx;
    logic [4*N_DIGITS-1:0]   shadow_data_r, shadow_data_nx;
    logic [N_DIGITS-1:0]     shadow_dp_r, shadow_dp_nx;
    logic [4*N_DIGITS-1:0]   pend_data_r, pend_data_nx;
    logic [N_DIGITS-1:0]     pend_dp_r, pend_dp_nx;
    logic                    pend_flag_r, pend_flag_nx;
    logic                    frame_done_nx;

    logic [3:0]              nib_s;
    logic                    dp_s;
    logic                    blank_s;
    logic [N_DIGITS-1:0]     lz_blank_s;
    logic [7:0]              dec_seg_s;
    logic [7:0]              seg_nx;
    logic [N_DIGITS-1:0]     an_nx;

    // Scan FSM, tick counter, digit index and pending/shadow buffer next-state
    always_comb begin
        state_nx       = state_r;
        cnt_nx         = cnt_r;
        idx_nx         = idx_r;
        shadow_data_nx = shadow_data_r;
        shadow_dp_nx   = shadow_dp_r;
        pend_data_nx   = pend_data_r;
        pend_dp_nx     = pend_dp_r;
        pend_flag_nx   = pend_flag_r;
        frame_done_nx  = 1'b0;

        if (DATA_VALID) begin
            pend_data_nx = DATA_IN;
            pend_dp_nx   = DP_IN;
            pend_flag_nx = 1'b1;
        end else begin
            pend_flag_nx = pend_flag_r;
        end

        if (!ENABLE) begin
            state_nx = IDLE;
            cnt_nx   = CNT_ZERO;
            idx_nx   = IDX_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx = LOAD;
                    cnt_nx   = CNT_ZERO;
                end
                LOAD: begin
                    state_nx = DRIVE;
                    cnt_nx   = CNT_ZERO;
                    idx_nx   = IDX_ZERO;
                    // A strobe landing in LOAD goes straight to the shadow
                    if (DATA_VALID) begin
                        shadow_data_nx = DATA_IN;
                        shadow_dp_nx   = DP_IN;
                        pend_data_nx   = pend_data_r;
                        pend_dp_nx     = pend_dp_r;
                        pend_flag_nx   = 1'b0;
                    end else if (pend_flag_r) begin
                        shadow_data_nx = pend_data_r;
                        shadow_dp_nx   = pend_dp_r;
                        pend_flag_nx   = 1'b0;
                    end else begin
                        shadow_data_nx = shadow_data_r;
                    end
                end
                DRIVE: begin
                    if (cnt_r == DIGIT_LAST) begin
                        cnt_nx = CNT_ZERO;
                        if (BLANK_TICKS > 0) begin
                            state_nx = BLANK;
                        end else if (idx_r == LAST_IDX) begin
                            state_nx      = LOAD;
                            frame_done_nx = 1'b1;
                        end else begin
                            state_nx = DRIVE;
                            idx_nx   = idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        cnt_nx = CNT_ZERO;
                        if (idx_r == LAST_IDX) begin
                            state_nx      = LOAD;
                            frame_done_nx = 1'b1;
                        end else begin
                            state_nx = DRIVE;
                            idx_nx   = idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = CNT_ZERO;
                    idx_nx   = IDX_ZERO;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nz_seen_s;

    // Digits above the most significant non-zero nibble are blanked; digit 0 never is
    always_comb begin
        lz_blank_s = {N_DIGITS{1'b0}};
        nz_seen_s  = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            nz_seen_s     = nz_seen_s | (shadow_data_nx[4*k +: 4] != 4'h0);
            lz_blank_s[k] = ~nz_seen_s;
        end
    end
`else
    // Every digit is always decoded
    always_comb begin
        lz_blank_s = {N_DIGITS{1'b0}};
    end
`endif

    // Select the digit about to be shown; outputs are computed from next-state
    // values so the registered pins change on the same edge as the FSM
    always_comb begin
        nib_s   = 4'h0;
        dp_s    = 1'b0;
        blank_s = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            nib_s   = (idx_nx == IDX_W'(k)) ? shadow_data_nx[4*k +: 4] : nib_s;
            dp_s    = (idx_nx == IDX_W'(k)) ? shadow_dp_nx[k]          : dp_s;
            blank_s = (idx_nx == IDX_W'(k)) ? lz_blank_s[k]            : blank_s;
        end
    end

    seg7_decoder u_dec (
        .nibble (nib_s),
        .dp     (dp_s),
        .seg    (dec_seg_s)
    );

    // Pin patterns: one anode low and decoded segments only while driving
    always_comb begin
        seg_nx = SEG_DARK;
        an_nx  = {N_DIGITS{1'b1}};
        if (state_nx == DRIVE) begin
            seg_nx = {dec_seg_s[7], blank_s ? 7'h7F : dec_seg_s[6:0]};
            for (int k = 0; k < N_DIGITS; k++) begin
                an_nx[k] = (idx_nx != IDX_W'(k));
            end
        end else begin
            seg_nx = SEG_DARK;
            an_nx  = {N_DIGITS{1'b1}};
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            idx_r         <= IDX_ZERO;
            shadow_data_r <= {(4*N_DIGITS){1'b0}};
            shadow_dp_r   <= {N_DIGITS{1'b0}};
            pend_data_r   <= {(4*N_DIGITS){1'b0}};
            pend_dp_r     <= {N_DIGITS{1'b0}};
            pend_flag_r   <= 1'b0;
            SEG_OUT       <= SEG_DARK;
            AN_OUT        <= {N_DIGITS{1'b1}};
            FRAME_DONE    <= 1'b0;
        end else begin
            state_r       <= state_nx;
            cnt_r         <= cnt_nx;
            idx_r         <= idx_nx;
            shadow_data_r <= shadow_data_nx;
            shadow_dp_r   <= shadow_dp_nx;
            pend_data_r   <= pend_data_nx;
            pend_dp_r     <= pend_dp_nx;
            pend_flag_r   <= pend_flag_nx;
            SEG_OUT       <= seg_nx;
            AN_OUT        <= an_nx;
            FRAME_DONE    <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Directed bench for seven_segment_mux_driver (4 digits, 4 lit ticks, 1 blank tick);
// expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_seven_segment_mux_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic [15:0] DATA_IN;
    logic [3:0]  DP_IN;
    logic        DATA_VALID;
    logic [7:0]  SEG_OUT;
    logic [3:0]  AN_OUT;
    logic        FRAME_DONE;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'hFF;
`else
    localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

    always #5 CLK = ~CLK;

    seven_segment_mux_driver #(
        .N_DIGITS    (4),
        .DIGIT_TICKS (4),
        .BLANK_TICKS (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .DATA_IN    (DATA_IN),
        .DP_IN      (DP_IN),
        .DATA_VALID (DATA_VALID),
        .SEG_OUT    (SEG_OUT),
        .AN_OUT     (AN_OUT),
        .FRAME_DONE (FRAME_DONE)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] seg_e, input logic [3:0] an_e,
                       input logic fd_e);
        checks++;
        assert (SEG_OUT === seg_e && AN_OUT === an_e && FRAME_DONE === fd_e)
        else begin
            errors++;
            $error("FAIL %s: SEG/AN/FD got %h/%h/%b expected %h/%h/%b",
                   tag, SEG_OUT, AN_OUT, FRAME_DONE, seg_e, an_e, fd_e);
        end
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] dp);
        DATA_IN    = d;
        DP_IN      = dp;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
    endtask

    // One full 21-cycle frame starting with the LOAD cycle; optional strobe at cycle sv_at
    task automatic frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3, input logic fd_e,
                         input int sv_at, input logic [15:0] sv_data, input logic [3:0] sv_dp);
        logic [7:0] segs [4];
        logic [7:0] se;
        logic [3:0] ae;
        int m;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int c = 0; c < 21; c++) begin
            if (c == sv_at) begin
                DATA_IN    = sv_data;
                DP_IN      = sv_dp;
                DATA_VALID = 1'b1;
            end
            tick();
            DATA_VALID = 1'b0;
            if (c == 0) begin
                chk(tag, 8'hFF, 4'hF, fd_e);
            end else begin
                m = c - 1;
                if ((m % 5) < 4) begin
                    se = segs[m / 5];
                    ae = ~(4'b0001 << (m / 5));
                end else begin
                    se = 8'hFF;
                    ae = 4'hF;
                end
                chk(tag, se, ae, 1'b0);
            end
        end
    endtask

    initial begin
        RST        = 1'b1;
        ENABLE     = 1'b0;
        DATA_VALID = 1'b0;
        DATA_IN    = 16'h0000;
        DP_IN      = 4'h0;
        #1;
        chk("reset", 8'hFF, 4'hF, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("idle_dark", 8'hFF, 4'hF, 1'b0);

        strobe(16'h1234, 4'h0);
        chk("strobe_idle", 8'hFF, 4'hF, 1'b0);

        ENABLE = 1'b1;
        frame("f1_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, -1, 16'h0000, 4'h0);
        frame("f2_mid_strobe", 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, 7, 16'hABCD, 4'h0);
        frame("f3_abcd", 8'hA1, 8'hC6, 8'h83, 8'h88, 1'b1, -1, 16'h0000, 4'h0);
        frame("f4_bypass_dp", 8'h99, 8'hB0, 8'h24, 8'hF9, 1'b1, 1, 16'h1234, 4'b0100);
        frame("f5_hold", 8'h99, 8'hB0, 8'h24, 8'hF9, 1'b1, -1, 16'h0000, 4'h0);

        // Disable in the middle of digit 2
        tick();
        chk("en_load", 8'hFF, 4'hF, 1'b1);
        repeat (12) tick();
        chk("mid_d2", 8'h24, 4'hB, 1'b0);
        ENABLE = 1'b0;
        tick();
        chk("disable_dark", 8'hFF, 4'hF, 1'b0);
        strobe(16'h0070, 4'h0);
        chk("disabled_strobe", 8'hFF, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("disabled_no_fd", 8'hFF, 4'hF, 1'b0);
        end

        ENABLE = 1'b1;
        frame("lz_0070", 8'hC0, 8'hF8, LZ_SEG, LZ_SEG, 1'b0, -1, 16'h0000, 4'h0);
        frame("lz_0000", 8'hC0, LZ_SEG, LZ_SEG, LZ_SEG, 1'b1, 0, 16'h0000, 4'h0);
        frame("f_5678", 8'h80, 8'hF8, 8'h82, 8'h92, 1'b1, 0, 16'h5678, 4'h0);

        // Reset while digit 0 is lit
        tick();
        tick();
        tick();
        chk("pre_reset_d0", 8'h80, 4'hE, 1'b0);
        RST    = 1'b1;
        ENABLE = 1'b0;
        #1;
        chk("reset_async", 8'hFF, 4'hF, 1'b0);
        tick();
        chk("reset_hold", 8'hFF, 4'hF, 1'b0);
        RST = 1'b0;
        tick();
        tick();
        chk("post_reset_dark", 8'hFF, 4'hF, 1'b0);
        ENABLE = 1'b1;
        frame("post_reset_zero", 8'hC0, LZ_SEG, LZ_SEG, LZ_SEG, 1'b0, -1, 16'h0000, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
